// File: rtl/inst_mem_responder.sv
// inst_mem_responder: instruction fetch responder with WAIT_CYCLES wait states; define INST_MEM_PROG_PORT_EN for a write port
module inst_mem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_mem_read,
  input  logic [31:0] inst_mem_address,
  input  logic        stall,
  output logic        inst_mem_ready,
  output logic        inst_mem_is_valid,
  output logic [31:0] inst_mem_read_data,
  output logic [1:0]  inst_mem_offset,
  output logic        inst_mem_error
`ifdef INST_MEM_PROG_PORT_EN
  ,
  input  logic                           prog_we,
  input  logic [$clog2(DEPTH_WORDS)-1:0] prog_addr,
  input  logic [31:0]                    prog_wdata
`endif
);
  localparam logic [1:0] IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2;
  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  off_q, off_d;
  logic        err_q, err_d;
  logic        accept, enter_resp, oor;
  logic [31:0] rd_addr, word;
  logic [29:0] widx;
  // Power-up program: word i holds "addi x1, x0, i-4", so word 4 is 32'h0000_0093
  function automatic logic [31:0] init_word(input logic [31:0] i);
    return 32'h0000_0093 | ((i - 32'd4) << 20);
  endfunction
`ifdef INST_MEM_PROG_PORT_EN
  typedef logic [31:0] mem_t [DEPTH_WORDS];
  function automatic mem_t init_mem();
    mem_t m;
    for (int k = 0; k < DEPTH_WORDS; k++) m[k] = init_word(32'(k));
    return m;
  endfunction
  mem_t mem_q = init_mem();
  // Program port writes on every edge, reset included; the fetch read sees the old word
  always_ff @(posedge clk)
    if (prog_we) mem_q[prog_addr] <= prog_wdata;
  assign word = mem_q[widx[$clog2(DEPTH_WORDS)-1:0]];
`else
  assign word = init_word({2'b00, widx});
`endif
  assign inst_mem_ready    = state_q == IDLE || (state_q == RESP && !stall);
  assign inst_mem_is_valid = state_q == RESP;
  assign accept            = inst_mem_read && inst_mem_ready;
  assign enter_resp        = (accept && WAIT_CYCLES == 0) || (state_q == WAIT && cnt_q == 4'd0);
  assign rd_addr           = state_q == WAIT ? addr_q : inst_mem_address;
  assign widx              = rd_addr[31:2];
  assign oor               = {2'b00, widx} >= 32'(DEPTH_WORDS);
  // Next-state and response capture
  always_comb begin
    state_d = accept ? (WAIT_CYCLES > 0 ? WAIT : RESP)
            : state_q == WAIT ? (cnt_q == 4'd0 ? RESP : WAIT)
            : state_q == RESP && !stall ? IDLE : state_q;
    cnt_d   = accept ? 4'(WAIT_CYCLES > 0 ? WAIT_CYCLES - 1 : 0)
            : state_q == WAIT && cnt_q != 4'd0 ? cnt_q - 4'd1 : cnt_q;
    addr_d  = accept ? inst_mem_address : addr_q;
    rdata_d = enter_resp ? (oor ? 32'h0000_0013 : word) : rdata_q;
    off_d   = enter_resp ? rd_addr[1:0] : off_q;
    err_d   = enter_resp ? oor : err_q;
  end
  // State registers with synchronous reset; array contents are untouched by reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      rdata_q <= '0;
      off_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      rdata_q <= rdata_d;
      off_q   <= off_d;
      err_q   <= err_d;
    end
  end
  assign inst_mem_read_data = rdata_q;
  assign inst_mem_offset    = off_q;
  assign inst_mem_error     = err_q;
endmodule

// File: tb/tb_inst_mem_responder.sv
// tb_inst_mem_responder: scoreboard bench for inst_mem_responder at WAIT_CYCLES=1 (dut1) and 0 (dut0)
module tb_inst_mem_responder;
  logic clk = 1'b0, reset = 1'b1, rd = 1'b0, stall = 1'b0;
  logic [31:0] addr = '0;
  logic r1, v1, e1, r0, v0, e0;
  logic [31:0] d1, d0;
  logic [1:0] o1, o0;
`ifdef INST_MEM_PROG_PORT_EN
  logic pwe = 1'b0;
  logic [9:0] pa = '0;
  logic [31:0] pd = '0;
`endif
  int vec = 0, errs = 0;
  typedef struct packed {logic [31:0] d; logic [1:0] o; logic e;} rsp_t;
  rsp_t q1[$], q0[$];
  rsp_t ex;
  always #5 clk = ~clk;
  inst_mem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(1)) dut1 (
    .clk(clk), .reset(reset), .inst_mem_read(rd), .inst_mem_address(addr), .stall(stall),
    .inst_mem_ready(r1), .inst_mem_is_valid(v1), .inst_mem_read_data(d1),
    .inst_mem_offset(o1), .inst_mem_error(e1)
`ifdef INST_MEM_PROG_PORT_EN
    , .prog_we(pwe), .prog_addr(pa), .prog_wdata(pd)
`endif
  );
  inst_mem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .inst_mem_read(rd), .inst_mem_address(addr), .stall(stall),
    .inst_mem_ready(r0), .inst_mem_is_valid(v0), .inst_mem_read_data(d0),
    .inst_mem_offset(o0), .inst_mem_error(e0)
`ifdef INST_MEM_PROG_PORT_EN
    , .prog_we(1'b0), .prog_addr(10'd0), .prog_wdata(32'd0)
`endif
  );
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset;
    reset = 1'b1; rd = 1'b0; stall = 1'b0;
    tick;
    reset = 1'b0;
    q0.delete(); q1.delete();
  endtask
  task automatic test_reset;
    reset = 1'b1; rd = 1'b1; addr = 32'h10;
    tick;
    reset = 1'b0; rd = 1'b0;
    #1;
    vec++; if ({r1, v1} !== 2'b10) begin errs++; $display("FAIL reset_ctl: ready,valid=%b want 10", {r1, v1}); end
    vec++; if ({d1, o1, e1} !== 35'd0) begin errs++; $display("FAIL reset_out: data=%h off=%b err=%b want zeros", d1, o1, e1); end
    tick;
    vec++; if ({v0, v1, r0, r1} !== 4'b0011) begin errs++; $display("FAIL reset_read_ignored: v0,v1,r0,r1=%b want 0011", {v0, v1, r0, r1}); end
  endtask
  task automatic test_basic;
    do_reset;
    rd = 1'b1; addr = 32'h10; q1.push_back(rsp_t'{32'h0000_0093, 2'd0, 1'b0});
    #1;
    vec++; if (r1 !== 1'b1) begin errs++; $display("FAIL basic_ready: got %b want 1", r1); end
    tick;
    rd = 1'b0;
    #1;
    vec++; if ({v1, r1} !== 2'b00) begin errs++; $display("FAIL basic_wait: valid,ready=%b want 00", {v1, r1}); end
    tick;
    vec++; if (v1 !== 1'b1) begin errs++; $display("FAIL basic_valid_cycle2: got %b want 1", v1); end
    if (q1.size() == 0) begin errs++; $display("FAIL basic_rsp: scoreboard empty"); end
    else begin
      ex = q1.pop_front(); vec++;
      if ({d1, o1, e1} !== ex) begin errs++; $display("FAIL basic_rsp: got %h/%b/%b want %h/%b/%b", d1, o1, e1, ex.d, ex.o, ex.e); end
    end
    tick;
    vec++; if ({v1, r1} !== 2'b01) begin errs++; $display("FAIL basic_idle: valid,ready=%b want 01", {v1, r1}); end
  endtask
  task automatic test_back_to_back;
    logic [31:0] a[3];
    rsp_t w[3];
    a = '{32'h0, 32'h4, 32'h8};
    w = '{rsp_t'{32'hFFC0_0093, 2'd0, 1'b0}, rsp_t'{32'hFFD0_0093, 2'd0, 1'b0}, rsp_t'{32'hFFE0_0093, 2'd0, 1'b0}};
    do_reset;
    for (int i = 0; i < 4; i++) begin
      rd = i < 3; addr = i < 3 ? a[i] : 32'h0;
      if (i < 3) q0.push_back(w[i]);
      #1;
      vec++; if (r0 !== 1'b1) begin errs++; $display("FAIL b2b_ready[%0d]: got %b want 1", i, r0); end
      if (i > 0) begin
        vec++; if (v0 !== 1'b1) begin errs++; $display("FAIL b2b_valid[%0d]: got %b want 1", i, v0); end
        if (q0.size() == 0) begin errs++; $display("FAIL b2b_rsp[%0d]: scoreboard empty", i); end
        else begin
          ex = q0.pop_front(); vec++;
          if ({d0, o0, e0} !== ex) begin errs++; $display("FAIL b2b_rsp[%0d]: got %h/%b/%b want %h/%b/%b", i, d0, o0, e0, ex.d, ex.o, ex.e); end
        end
      end
      tick;
    end
    vec++; if (v0 !== 1'b0) begin errs++; $display("FAIL b2b_idle: valid=%b want 0", v0); end
  endtask
  task automatic test_stall;
    do_reset;
    rd = 1'b1; addr = 32'h4; q1.push_back(rsp_t'{32'hFFD0_0093, 2'd0, 1'b0});
    tick;
    rd = 1'b0;
    tick;
    stall = 1'b1; rd = 1'b1; addr = 32'h8;
    #1;
    if (q1.size() == 0) begin errs++; $display("FAIL stall_rsp: scoreboard empty"); end
    else ex = q1.pop_front();
    for (int i = 0; i < 4; i++) begin
      if (i == 3) begin stall = 1'b0; rd = 1'b0; end
      #1;
      vec++; if ({v1, r1} !== {1'b1, i == 3}) begin errs++; $display("FAIL stall_ctl[%0d]: valid,ready=%b want 1%b", i, {v1, r1}, i == 3); end
      vec++; if ({d1, o1, e1} !== ex) begin errs++; $display("FAIL stall_hold[%0d]: got %h/%b/%b want %h/%b/%b", i, d1, o1, e1, ex.d, ex.o, ex.e); end
      tick;
    end
    for (int i = 0; i < 3; i++) begin
      vec++; if (v1 !== 1'b0) begin errs++; $display("FAIL stall_dropped[%0d]: valid=%b want 0", i, v1); end
      tick;
    end
  endtask
  task automatic test_range;
    logic [31:0] a[3];
    rsp_t w[3];
    a = '{32'h0000_1000, 32'h6, 32'hFFF};
    w = '{rsp_t'{32'h0000_0013, 2'd0, 1'b1}, rsp_t'{32'hFFD0_0093, 2'd2, 1'b0}, rsp_t'{32'h3FB0_0093, 2'd3, 1'b0}};
    do_reset;
    for (int i = 0; i < 4; i++) begin
      rd = i < 3; addr = i < 3 ? a[i] : 32'h0;
      if (i < 3) q0.push_back(w[i]);
      #1;
      if (i > 0) begin
        if (q0.size() == 0) begin errs++; $display("FAIL range_rsp[%0d]: scoreboard empty", i); end
        else begin
          ex = q0.pop_front(); vec++;
          if ({v0, d0, o0, e0} !== {1'b1, ex}) begin errs++; $display("FAIL range_rsp[%0d]: got v=%b %h/%b/%b want %h/%b/%b", i, v0, d0, o0, e0, ex.d, ex.o, ex.e); end
        end
      end
      tick;
    end
  endtask
  task automatic test_reset_in_wait;
    do_reset;
    rd = 1'b1; addr = 32'h10;
    tick;
    rd = 1'b0; reset = 1'b1;
    #1;
    vec++; if (v1 !== 1'b0) begin errs++; $display("FAIL rstwait_wait: valid=%b want 0", v1); end
    tick;
    reset = 1'b0;
    #1;
    vec++; if ({v1, r1} !== 2'b01) begin errs++; $display("FAIL rstwait_idle: valid,ready=%b want 01", {v1, r1}); end
    tick;
    vec++; if (v1 !== 1'b0) begin errs++; $display("FAIL rstwait_discard: valid=%b want 0", v1); end
    rd = 1'b1; addr = 32'h14; q1.push_back(rsp_t'{32'h0010_0093, 2'd0, 1'b0});
    tick;
    rd = 1'b0;
    tick;
    if (q1.size() == 0) begin errs++; $display("FAIL rstwait_rsp: scoreboard empty"); end
    else begin
      ex = q1.pop_front(); vec++;
      if ({v1, d1, o1, e1} !== {1'b1, ex}) begin errs++; $display("FAIL rstwait_rsp: got v=%b %h/%b/%b want %h", v1, d1, o1, e1, ex.d); end
    end
  endtask
`ifdef INST_MEM_PROG_PORT_EN
  task automatic test_prog;
    do_reset;
    rd = 1'b1; addr = 32'h8; q1.push_back(rsp_t'{32'hFFE0_0093, 2'd0, 1'b0});
    tick;
    rd = 1'b0; pwe = 1'b1; pa = 10'd2; pd = 32'hDEAD_BEEF;
    tick;
    pwe = 1'b0;
    ex = q1.pop_front(); vec++;
    if ({v1, d1} !== {1'b1, ex.d}) begin errs++; $display("FAIL prog_old: got v=%b %h want %h", v1, d1, ex.d); end
    tick;
    rd = 1'b1; q1.push_back(rsp_t'{32'hDEAD_BEEF, 2'd0, 1'b0});
    tick;
    rd = 1'b0;
    tick;
    ex = q1.pop_front(); vec++;
    if ({v1, d1} !== {1'b1, ex.d}) begin errs++; $display("FAIL prog_new: got v=%b %h want %h", v1, d1, ex.d); end
  endtask
`endif
  initial begin
    test_reset;
    test_basic;
    test_back_to_back;
    test_stall;
    test_range;
    test_reset_in_wait;
`ifdef INST_MEM_PROG_PORT_EN
    test_prog;
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule

// File: doc/inst_mem_responder.md
INST_MEM_RESPONDER -- requirements
Module: inst_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024: number of 32-bit words in the instruction array.
REQ-002 SHALL have parameter WAIT_CYCLES, default 1, range 0..15: extra wait states added before each response.
REQ-003 SHALL have port clk, input, 1 bit: the only clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port inst_mem_read, input, 1 bit: fetch request strobe.
REQ-006 SHALL have port inst_mem_address, input, 32 bits: byte address of the fetch.
REQ-007 SHALL have port stall, input, 1 bit: consumer not ready; holds the current response.
REQ-008 SHALL have port inst_mem_ready, output, 1 bit: a request is accepted this cycle.
REQ-009 SHALL have port inst_mem_is_valid, output, 1 bit: response data is valid.
REQ-010 SHALL have port inst_mem_read_data, output, 32 bits: fetched instruction.
REQ-011 SHALL have port inst_mem_offset, output, 2 bits: byte offset (address[1:0]) of the answered request.
REQ-012 SHALL have port inst_mem_error, output, 1 bit: answered request was out of range.

Function
REQ-013 SHALL implement the states IDLE, WAIT and RESP.
REQ-014 SHALL drive inst_mem_ready=1 in IDLE, and in RESP when stall=0; inst_mem_ready=0 otherwise.
REQ-015 SHALL accept a request only on a cycle with inst_mem_read=1 and inst_mem_ready=1, latching the address; a request with inst_mem_ready=0 is dropped and gets no response.
REQ-016 SHALL move an accepted request to WAIT when WAIT_CYCLES>0 (counter loaded with WAIT_CYCLES-1) and directly to RESP when WAIT_CYCLES=0.
REQ-017 SHALL decrement the WAIT counter once per cycle and enter RESP on the edge where it reads 0.
REQ-018 SHALL raise inst_mem_is_valid exactly WAIT_CYCLES+1 cycles after the accepting edge.
REQ-019 SHALL register inst_mem_read_data, inst_mem_offset and inst_mem_error on the edge that enters RESP, and hold them stable while in RESP.
REQ-020 SHALL keep the design in RESP with all outputs frozen while stall=1.
REQ-021 SHALL leave RESP when stall=0: to IDLE with no new request, or handling a simultaneous new request per REQ-016, giving back-to-back throughput of one per cycle at WAIT_CYCLES=0.
REQ-022 SHALL index the array by word index address[31:2], ignoring address[1:0] for data selection.
REQ-023 SHALL treat a word index >= DEPTH_WORDS as out of range: inst_mem_read_data=32'h0000_0013 (NOP), inst_mem_error=1.
REQ-024 SHALL drive inst_mem_is_valid=0 in IDLE and WAIT.
REQ-025 SHALL allow inst_mem_read_data, inst_mem_offset and inst_mem_error to keep their last values outside RESP; consumers qualify them with inst_mem_is_valid.

Reset
REQ-026 SHALL, on reset=1 at a rising edge, enter IDLE and clear the counter and latched address, with inst_mem_is_valid=0, inst_mem_read_data=0, inst_mem_offset=0, inst_mem_error=0 and inst_mem_ready=1 from the next cycle.
REQ-027 SHALL discard any in-flight request when reset is asserted in WAIT or RESP; no response is produced for it.
REQ-028 SHALL ignore inst_mem_read on any cycle where reset=1.
REQ-029 SHALL not clear the array contents on reset.

Configuration
REQ-030 SHALL, with macro INST_MEM_PROG_PORT_EN defined, add inputs prog_we (1 bit), prog_addr (word index, clog2(DEPTH_WORDS) bits) and prog_wdata (32 bits) that write the array on any edge with prog_we=1, reset included.
REQ-031 SHALL, with INST_MEM_PROG_PORT_EN defined, return the old word when a prog write and the RESP-entry read hit the same word on the same edge (read-before-write).
REQ-032 SHALL, without INST_MEM_PROG_PORT_EN, omit the prog ports and make the array read-only, loaded only at elaboration.

Verification
REQ-033 SHALL cover: WAIT_CYCLES=1, word 4 = 32'h0000_0093, request address 32'h10 at cycle 0 -> is_valid=1 at cycle 2, data 32'h0000_0093, offset 0, error 0.
REQ-034 SHALL cover: WAIT_CYCLES=0, requests to 0x0, 0x4 and 0x8 on consecutive cycles -> three consecutive valid responses in order, ready held at 1.
REQ-035 SHALL cover: stall=1 for 3 cycles during RESP -> data and valid held for 4 cycles, ready=0, a request issued while stalled is dropped.
REQ-036 SHALL cover: DEPTH_WORDS=1024, address 32'h0000_1000 -> data 32'h0000_0013, error 1; address 32'h6 -> offset 2'b10, data = word 1.
REQ-037 SHALL cover: reset asserted in WAIT -> is_valid stays 0, next cycle IDLE with ready=1, and a later request answered normally.
REQ-038 SHALL cover, with INST_MEM_PROG_PORT_EN: prog write of 32'hDEAD_BEEF to word 2 on the RESP-entry edge of a fetch of 0x8 -> old word returned; a repeat fetch returns 32'hDEAD_BEEF.
